// File: rtl/tone_sequencer_if.sv
// Control/status bundle between a tone sequencer and whoever drives it.
// The sequencer is the slave: it takes play/direction/loop_en and returns the divider controls.
interface tone_sequencer_if #(
  parameter int N = 32
);
  logic         play;
  logic         direction;
  logic         loop_en;
  logic [N-1:0] freq_counter;
  logic         on_off;
  logic [2:0]   note_index;
  logic         done;

  modport master (
    output play, direction, loop_en,
    input  freq_counter, on_off, note_index, done
  );

  modport slave (
    input  play, direction, loop_en,
    output freq_counter, on_off, note_index, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// Steps an 8-note table (C4..C5 at 50 MHz) at a fixed tempo, feeding period and enable
// to the clock divider, with a silent gap after every note.
module tone_sequencer #(
  parameter int N           = 32,
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic             in_clk,
  input  logic             reset_n,
  tone_sequencer_if.slave  bus
);

  localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } state_e;

  // NOTE: the note table is a pure constant function, so it synthesises to logic with
  // nothing to reset; only freq_q, which holds the looked-up value, needs a reset value.
  function automatic logic [N-1:0] note_period(input logic [2:0] idx);
    logic [31:0] p;
    case (idx)
      3'd0:    p = 32'd191113;
      3'd1:    p = 32'd170262;
      3'd2:    p = 32'd151685;
      3'd3:    p = 32'd143172;
      3'd4:    p = 32'd127551;
      3'd5:    p = 32'd113636;
      3'd6:    p = 32'd101238;
      default: p = 32'd95556;
    endcase
    return N'(p);
  endfunction

  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      idx_q;
  logic [N-1:0]    freq_q;
  logic            on_q;
  logic            done_q;
  logic            play_q;

  logic            rise;
  logic [2:0]      idx_d;
  logic            pass_end;

  assign rise = bus.play & ~play_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // and infers a latch.
  always_comb begin
    idx_d    = idx_q;
    pass_end = 1'b0;
    if (bus.direction) begin
      idx_d    = idx_q - 3'd1;
      pass_end = (idx_q == 3'd0);
    end else begin
      idx_d    = idx_q + 3'd1;
      pass_end = (idx_q == 3'd7);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every register samples
  // the pre-edge values and the block order does not matter.
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= 3'd0;
      freq_q  <= note_period(3'd0);
      on_q    <= 1'b0;
      done_q  <= 1'b0;
      play_q  <= 1'b1;   // a play held through reset is not a rising edge
    end else begin
      play_q <= bus.play;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          on_q    <= 1'b0;
          if (rise) begin
            state_q <= NOTE;
            on_q    <= 1'b1;
          end
        end

        NOTE: begin
          if (!bus.play) begin
            state_q <= IDLE;
            timer_q <= '0;
            on_q    <= 1'b0;
          end else if (timer_q == NOTE_LAST) begin
            state_q <= GAP;
            timer_q <= '0;
            on_q    <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        GAP: begin
          if (!bus.play) begin
            // Stop beats advance: index stays put and no done pulse.
            state_q <= IDLE;
            timer_q <= '0;
            on_q    <= 1'b0;
          end else if (timer_q == GAP_LAST) begin
            timer_q <= '0;
            idx_q   <= idx_d;
            freq_q  <= note_period(idx_d);
            if (pass_end && !bus.loop_en) begin
              state_q <= IDLE;
              on_q    <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= NOTE;
              on_q    <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          timer_q <= '0;
          on_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freq_counter = freq_q;
  assign bus.on_off       = on_q;
  assign bus.note_index   = idx_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed scenarios plus random play/direction/loop/reset traffic, checked every cycle
// against a slot-position model of the sequencer.
module tb_tone_sequencer;

  localparam int N  = 32;
  localparam int NC = 4;
  localparam int GC = 2;

  logic in_clk;
  logic reset_n;

  tone_sequencer_if #(.N(N)) bus ();

  tone_sequencer #(
    .N           (N),
    .NOTE_CYCLES (NC),
    .GAP_CYCLES  (GC)
  ) dut (
    .in_clk  (in_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: a note occupies a slot of NC+GC cycles; pos is the position inside it.
  int  rom_t [8] = '{191113, 170262, 151685, 143172, 127551, 113636, 101238, 95556};
  int  m_idx    = 0;
  int  m_pos    = 0;
  bit  m_active = 0;
  bit  m_done   = 0;
  bit  m_prev   = 1;

  task automatic model_step();
    bit rise, at_end;
    if (!reset_n) begin
      m_idx = 0; m_pos = 0; m_active = 0; m_done = 0; m_prev = 1;
    end else begin
      rise   = bus.play && !m_prev;
      m_prev = bus.play;
      m_done = 0;
      if (!m_active) begin
        if (rise) begin
          m_active = 1;
          m_pos    = 0;
        end
      end else if (!bus.play) begin
        m_active = 0;
      end else if (m_pos == NC + GC - 1) begin
        at_end = bus.direction ? (m_idx == 0) : (m_idx == 7);
        m_idx  = (m_idx + (bus.direction ? 7 : 1)) % 8;
        m_pos  = 0;
        if (at_end && !bus.loop_en) begin
          m_done   = 1;
          m_active = 0;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    model_step();
    @(negedge in_clk);
    check("freq_counter", bus.freq_counter, rom_t[m_idx]);
    check("note_index", bus.note_index, m_idx);
    check("on_off", bus.on_off, (m_active && m_pos < NC) ? 1 : 0);
    check("done", bus.done, m_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int first_on, done_at, done_cnt, cnt;
  bit seen;

  initial begin
    reset_n       = 1'b0;
    bus.play      = 1'b1;
    bus.direction = 1'b0;
    bus.loop_en   = 1'b0;

    // 1: reset with play held high; no start afterwards
    run(3);
    reset_n = 1'b1;
    run(6);
    check("t1_on_off", bus.on_off, 0);
    check("t1_freq", bus.freq_counter, 191113);
    check("t1_idx", bus.note_index, 0);
    check("t1_done", bus.done, 0);

    // 2: ascending single pass
    bus.play = 1'b0;
    tick();
    bus.play = 1'b1;
    first_on = -1; done_at = -1; done_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.on_off && first_on < 0) first_on = i;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    check("t2_done_latency", done_at - first_on, 48);
    check("t2_done_width", done_cnt, 1);
    check("t2_idx_after", bus.note_index, 0);
    check("t2_on_after", bus.on_off, 0);

    // 3: descending from reset, then a full descending pass
    reset_n = 1'b0; bus.play = 1'b0; bus.direction = 1'b1;
    run(2);
    reset_n = 1'b1;
    tick();
    bus.play = 1'b1;
    run(12);
    check("t3_idx_first", bus.note_index, 7);
    bus.play = 1'b0;
    tick();
    bus.play = 1'b1;
    run(8 * (NC + GC) + 4);
    check("t3_idx_second", bus.note_index, 7);
    check("t3_on_second", bus.on_off, 0);

    // 4: ascending looping, then drop loop_en
    bus.direction = 1'b0; bus.loop_en = 1'b1; bus.play = 1'b0;
    tick();
    bus.play = 1'b1;
    run(70);
    bus.loop_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1;
    end
    check("t4_done_seen", seen, 1);

    // 5: stop during note 3 at timer 2, then resume
    bus.play = 1'b0;
    tick();
    bus.play = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (m_active && m_idx == 3 && m_pos == 2) seen = 1;
    end
    check("t5_reached", seen, 1);
    bus.play = 1'b0;
    tick();
    check("t5_stop_on", bus.on_off, 0);
    check("t5_stop_idx", bus.note_index, 3);
    bus.play = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.on_off && bus.freq_counter == 143172) cnt++;
    end
    check("t5_note_len", cnt, 4);

    // 6: reset during the gap of note 5
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (m_active && m_idx == 5 && m_pos >= NC) seen = 1;
    end
    check("t6_reached", seen, 1);
    reset_n = 1'b0;
    tick();
    check("t6_rst_freq", bus.freq_counter, 191113);
    check("t6_rst_idx", bus.note_index, 0);
    check("t6_rst_on", bus.on_off, 0);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.on_off) cnt++;
    end
    check("t6_no_restart", cnt, 0);
    bus.play = 1'b0;
    tick();
    bus.play = 1'b1;
    tick();
    check("t6_restart_on", bus.on_off, 1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(39, 0) == 0) bus.play = ~bus.play;
      if ($urandom_range(19, 0) == 0) bus.direction = 1'($urandom_range(1, 0));
      if ($urandom_range(19, 0) == 0) bus.loop_en = 1'($urandom_range(1, 0));
      reset_n = ($urandom_range(299, 0) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Upstream control stage for the arbitrary clock divider in the audio path.
- Steps through a fixed 8-entry note table (C4..C5 at 50 MHz) at a fixed tempo.
- Drives the divider's period word (freq_counter) and its enable (on_off).
- Inserts a silent gap between notes, and supports start/stop, direction and looping.

Parameters:
- N, 32, width of freq_counter; must match the divider's N.
- NOTE_CYCLES, 25000000, in_clk cycles a note sounds (≥1).
- GAP_CYCLES, 2500000, in_clk cycles of silence after each note (≥1).

Ports:
- in_clk  input  1  system clock (50 MHz).
- reset_n  input  1  synchronous active-low reset.
- play  input  1  level; a rising edge starts or resumes the sequence; low stops it.
- direction  input  1  0 = ascending index, 1 = descending; sampled only at note advance.
- loop_en  input  1  1 = wrap at end of table; 0 = stop at end; sampled only at note advance.
- freq_counter  output  N  period word to the divider = ROM[note_index].
- on_off  output  1  divider enable; 1 only while a note sounds.
- note_index  output  3  current table index.
- done  output  1  one-cycle pulse at end of a non-looping pass.

Behaviour:
- One clock (in_clk). Reset is synchronous, active-low (reset_n). All outputs are registered.
- Note ROM, index 0..7: 191113, 170262, 151685, 143172, 127551, 113636, 101238, 95556. Values are zero-extended to N bits.
- Reset (reset_n=0 at an edge):
  - state=IDLE, note_index=0, freq_counter=191113, on_off=0, done=0, timer=0.
  - play_d resets to 1, so a play held high through reset does not start the sequence.
- Start detect: rise = play & ~play_d. play_d is registered every cycle.
- Timer width is $clog2(max(NOTE_CYCLES, GAP_CYCLES)+1). The timer is cleared on every state change.
- States:
  - IDLE: on_off=0, timer=0. On rise → NOTE. on_off=1 from the edge that samples the rise (1-cycle latency).
  - NOTE: on_off=1. Timer counts 0..NOTE_CYCLES-1. At NOTE_CYCLES-1 → GAP, and on_off=0 at that edge. on_off is therefore high for exactly NOTE_CYCLES cycles.
  - GAP: on_off=0. Timer counts 0..GAP_CYCLES-1. At GAP_CYCLES-1 the sequencer advances (see below).
- Advance, ascending:
  - index<7: index+1 → NOTE.
  - index==7 and loop_en=1: index=0 → NOTE.
  - index==7 and loop_en=0: done=1 for one cycle, index=0 → IDLE.
- Advance, descending:
  - index>0: index-1 → NOTE.
  - index==0 and loop_en=1: index=7 → NOTE.
  - index==0 and loop_en=0: done=1, index=7 → IDLE.
- freq_counter updates on the same edge as note_index, so the two are always consistent and never glitch mid-note.
- Stop: play=0 sampled in NOTE or GAP → IDLE on that edge. on_off=0, timer cleared, note_index retained, done not asserted. The next rise replays the current note from timer 0.
- Simultaneous stop and advance: stop wins. State goes to IDLE, the index does not advance, and done is not asserted.
- After done, play still high does not restart. A low-then-high transition is required.
- reset_n=0 mid-note or mid-gap takes priority over everything and forces the reset values.

Test Plan:
- Bench parameters: NOTE_CYCLES=4, GAP_CYCLES=2.
1. Reset with play=1 held, then release reset → on_off=0, freq_counter=191113, note_index=0, done=0; stays in IDLE while play remains high.
2. play 0→1, direction=0, loop_en=0 → on_off pattern 4 high / 2 low ×8 with freq_counter stepping 191113…95556; done high for exactly 1 cycle, 48 cycles after the first on_off=1; then note_index=0 and on_off=0.
3. direction=1, loop_en=0, start from reset → one note at 191113, then done pulse, note_index=7. Restart → plays 95556 down to 191113 (8 notes), done, note_index=7.
4. direction=0, loop_en=1 → after index 7 the gap is followed by index 0 (191113) with no done pulse. Set loop_en=0 mid-pass → done fires at the next index-7 advance.
5. Drop play during NOTE at timer=2 on index 3 → on_off=0 on the next edge, note_index=3. Re-raise play → index 3 (143172) sounds a full 4 cycles.
6. Assert reset_n=0 during GAP on index 5 with play high → reset values on the next edge; no restart until play goes low and then high again.
